// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: in-order queue of fetched branch predictions, resolved oldest-first
// into predictor/BTB update bundles plus mispredict flush and redirect.
module branch_resolve_queue #(
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push_valid,
    input  logic [31:0]      i_push_pc,
    input  logic             i_push_prd_taken,
    input  logic [31:0]      i_push_prd_target,
    output logic             o_full,
    input  logic             i_res_valid,
    input  logic             i_res_taken,
    input  logic [31:0]      i_res_target,
    output logic             o_br_update_en,
    output logic             o_br_update_valid,
    output logic             o_br_update_taken,
    output logic [31:0]      o_br_update_pc,
    output logic [31:0]      o_br_update_target,
    output logic             o_flush,
    output logic [31:0]      o_redirect_pc,
    output logic [PTR_W:0]   o_count,
    output logic [1:0]       o_err
);
    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;
    localparam logic [PTR_W:0] L_FULL = (PTR_W+1)'(DEPTH);

    logic [31:0]      r_pc  [DEPTH];
    logic             r_pt  [DEPTH];
    logic [31:0]      r_tgt [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic [0:0]       r_state;
    logic             r_upd_en;
    logic             r_upd_taken;
    logic [31:0]      r_upd_pc;
    logic [31:0]      r_upd_target;
    logic             r_flush;
    logic [31:0]      r_redirect;
    logic [1:0]       r_err;

    logic        w_run;
    logic        w_full;
    logic        w_empty;
    logic        w_res_acc;
    logic        w_mispred;
    logic        w_push_acc;
    logic        w_overflow;
    logic        w_underflow;
    logic [31:0] w_head_pc;
    logic        w_head_pt;
    logic [31:0] w_head_tgt;

    assign w_run       = (r_state == ST_RUN);
    assign w_full      = (r_count == L_FULL);
    assign w_empty     = (r_count == '0);
    assign w_head_pc   = r_pc[r_rd_ptr];
    assign w_head_pt   = r_pt[r_rd_ptr];
    assign w_head_tgt  = r_tgt[r_rd_ptr];
    assign w_res_acc   = i_res_valid & w_run & ~w_empty;
    assign w_mispred   = (w_head_pt != i_res_taken) | (i_res_taken & w_head_pt & (w_head_tgt != i_res_target));
    // A pop in the same cycle frees a slot, but a mispredicting pop squashes the younger push.
    assign w_push_acc  = i_push_valid & w_run & ~(w_res_acc & w_mispred) & (~w_full | w_res_acc);
    assign w_overflow  = i_push_valid & w_run & w_full & ~w_res_acc;
    assign w_underflow = i_res_valid & w_run & w_empty;

    always_ff @(posedge i_clk) begin
        if (w_push_acc) begin
            r_pc[r_wr_ptr]  <= i_push_pc;
            r_pt[r_wr_ptr]  <= i_push_prd_taken;
            r_tgt[r_wr_ptr] <= i_push_prd_target;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_state  <= ST_RUN;
        end else if (w_res_acc && w_mispred) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_state  <= ST_FLUSH;
        end else begin
            r_wr_ptr <= w_push_acc ? r_wr_ptr + PTR_W'(1) : r_wr_ptr;
            r_rd_ptr <= w_res_acc ? r_rd_ptr + PTR_W'(1) : r_rd_ptr;
            r_count  <= r_count + (PTR_W+1)'(w_push_acc) - (PTR_W+1)'(w_res_acc);
            r_state  <= ST_RUN;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_upd_en     <= 1'b0;
            r_upd_taken  <= 1'b0;
            r_upd_pc     <= '0;
            r_upd_target <= '0;
            r_flush      <= 1'b0;
            r_redirect   <= '0;
            r_err        <= '0;
        end else begin
            r_upd_en <= w_res_acc;
            r_flush  <= w_res_acc & w_mispred;
            r_err    <= r_err | {w_underflow, w_overflow};
            if (w_res_acc) begin
                r_upd_taken  <= i_res_taken;
                r_upd_pc     <= w_head_pc;
                r_upd_target <= i_res_target;
            end
            if (w_res_acc && w_mispred)
                r_redirect <= i_res_taken ? i_res_target : w_head_pc + 32'd4;
        end
    end

    assign o_full             = w_full;
    assign o_count            = r_count;
    assign o_br_update_en     = r_upd_en;
    assign o_br_update_valid  = r_upd_en;
    assign o_br_update_taken  = r_upd_taken;
    assign o_br_update_pc     = r_upd_pc;
    assign o_br_update_target = r_upd_target;
    assign o_flush            = r_flush;
    assign o_redirect_pc      = r_redirect;
    assign o_err              = r_err;
endmodule

// File: doc/branch_resolve_queue.md
Name: branch_resolve_queue

Overview:
- Fetch-to-execute tracker for in-flight branch predictions.
- Fetch pushes the PC, predicted direction and predicted target of every fetched branch into an in-order queue.
- When the branch unit (BRU) resolves the oldest branch, the block compares the actual outcome with the prediction. It then generates the update bundle consumed by the predictor/BTB, plus a mispredict flush and redirect PC for next-PC selection.
- It is the producer side of the predictor's update interface.

Parameters:
- DEPTH, 8, number of queue entries; must be a power of 2 and at least 2.
- PTR_W, $clog2(DEPTH), read/write pointer width; occupancy counter is PTR_W+1 bits.

Ports:
- i_clk  in  1  clock. Single clock domain: one clock; reset is synchronous and active-high.
- i_rst  in  1  synchronous, active-high reset.
- i_push_valid  in  1  fetch has a branch to record this cycle.
- i_push_pc  in  32  PC of the fetched branch.
- i_push_prd_taken  in  1  predicted-taken bit at fetch.
- i_push_prd_target  in  32  predicted target (don't-care if not taken).
- o_full  out  1  queue full; fetch must stall branch issue.
- i_res_valid  in  1  BRU resolved the oldest outstanding branch.
- i_res_taken  in  1  actual direction.
- i_res_target  in  32  actual target.
- o_br_update_en  out  1  update strobe to predictor/BTB.
- o_br_update_valid  out  1  update carries a real resolved branch.
- o_br_update_taken  out  1  actual direction.
- o_br_update_pc  out  32  PC of the resolved branch.
- o_br_update_target  out  32  actual target.
- o_flush  out  1  mispredict; squash younger instructions.
- o_redirect_pc  out  32  correct next PC when o_flush=1.
- o_count  out  PTR_W+1  current occupancy.
- o_err  out  2  sticky error flags: [0] push while full, [1] resolve while empty.

Behaviour:
- Reset (synchronous, active-high):
  - Pointers and count go to 0; FSM goes to RUN.
  - All outputs are 0: o_br_update_*=0, o_flush=0, o_redirect_pc=0, o_err=0, o_full=0, o_count=0.
  - Reset mid-operation discards all entries and any pending update.
- Queue: circular buffer. Write pointer wraps DEPTH-1 -> 0, as does the read pointer.
  - o_full = (count == DEPTH), combinational from the registered count.
  - o_count is registered.
- Push is accepted when i_push_valid=1, not full, and FSM=RUN.
  - A push while full is dropped and sets o_err[0].
  - A push during FLUSH is dropped silently (wrong-path fetch).
- Resolve is accepted when i_res_valid=1 and count>0. It pops the head entry.
  - A resolve while empty is ignored and sets o_err[1].
- Compare on the popped entry:
  - mispredict = (prd_taken != i_res_taken) | (i_res_taken & prd_taken & (prd_target != i_res_target)).
- Update outputs are registered, with latency 1 cycle after the accepted resolve, and pulse for exactly one cycle:
  - o_br_update_en=1 and o_br_update_valid=1.
  - taken/target come from i_res_*; pc comes from the entry.
  - With no accepted resolve, o_br_update_en=0 and o_br_update_valid=0.
- Redirect: on mispredict, in the same registered cycle as the update:
  - o_flush=1.
  - o_redirect_pc = i_res_taken ? i_res_target : entry_pc + 32'd4 (modulo 2^32).
  - The queue is cleared (count=0, pointers=0) and the FSM goes to FLUSH.
- FSM:
  - RUN -> FLUSH on an accepted mispredicting resolve.
  - FLUSH -> RUN unconditionally after 1 cycle.
  - In FLUSH, pushes and resolves are ignored; resolves do not set error flags.
- Simultaneous push and resolve in RUN:
  - Both take effect and count is unchanged.
  - If the resolve mispredicts, the same-cycle push is discarded (younger).
  - Push is permitted when full if a non-mispredicting pop occurs the same cycle.
- A correct prediction never asserts o_flush; o_redirect_pc holds its last value.
- o_err bits are cleared only by reset.

Test Plan:
- Correct taken: push pc=0x100, prd_taken=1, tgt=0x200; resolve taken=1, tgt=0x200 -> next cycle update_en=1, taken=1, pc=0x100, target=0x200, flush=0, count=0.
- Direction miss, not-taken actual: push 0x104/prd_taken=1; resolve taken=0 -> update_en=1, taken=0, flush=1, redirect=0x108; pushes in the following cycle dropped; count=0.
- Target miss plus younger squash:
  - Push 0x10, 0x20, 0x30 (all prd_taken=1, tgt=0x80).
  - Resolve 0x10 with taken=1, tgt=0x90 -> flush=1, redirect=0x90, count=0.
  - Next resolve is ignored (FLUSH) with o_err=0.
- Full/wrap: DEPTH=8; push 8 entries -> o_full=1. 9th push dropped, o_err[0]=1. Push+correct resolve same cycle -> accepted, count=8. Drain 8 -> PCs pop in order across the pointer wrap.
- Underflow: resolve on empty queue -> no update_en, o_err[1]=1.
- Mid-operation reset: reset with count=5 and a mispredict resolve in the same cycle -> next cycle all outputs 0, count=0, FSM=RUN.
